// File: rtl/lfsr_seq_pkg.sv
// Shared widths, FSM state type and the Galois LFSR step for the pattern sequencer.
// Pure definitions: no latency and no flow control of their own.
package lfsr_seq_pkg;

    localparam int LFSR_W = 8;
    localparam int ADDR_W = 8;
    localparam int TAP_W  = 7;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    // Tap bit k feeds the MSB back into q[7-k]; bit 0 always receives the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q,
                                                    input logic [TAP_W-1:0]  taps);
        logic              t;
        logic [LFSR_W-1:0] n;
        t    = q[LFSR_W-1];
        n[0] = t;
        for (int i = 1; i < LFSR_W; i++) begin
            n[i] = q[i-1] ^ (taps[LFSR_W-1-i] & t);
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr_pattern_sequencer_if.sv
// Control, status and memory-write bundle between the controller and the sequencer.
// No latency and no backpressure: the memory port accepts one write per cycle.
interface lfsr_pattern_sequencer_if;
    import lfsr_seq_pkg::*;

    logic              start;
    logic              abort;
    logic [TAP_W-1:0]  cfg_taps;
    logic [LFSR_W-1:0] cfg_seed;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_stride;
    logic [7:0]        cfg_count;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LFSR_W-1:0] mem_wdata;
    logic [LFSR_W-1:0] lfsr_q;
    logic [TAP_W-1:0]  tap_loc;
    logic [7:0]        words_left;

    modport master (
        output start, abort, cfg_taps, cfg_seed, cfg_base, cfg_stride, cfg_count,
        input  busy, done, aborted, mem_we, mem_addr, mem_wdata, lfsr_q, tap_loc, words_left
    );

    modport slave (
        input  start, abort, cfg_taps, cfg_seed, cfg_base, cfg_stride, cfg_count,
        output busy, done, aborted, mem_we, mem_addr, mem_wdata, lfsr_q, tap_loc, words_left
    );

endinterface

// File: rtl/lfsr_shift_reg.sv
// 8-bit Galois LFSR register: load wins over step; one-cycle update latency.
// No backpressure: holds its value when neither load nor step is asserted.
module lfsr_shift_reg
    import lfsr_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    input  logic [TAP_W-1:0]  taps,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (step) begin
            q_d = lfsr_next(q_q, taps);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_pattern_sequencer.sv
// Runs one LFSR sequence per start and writes each state to memory at base + n*stride.
// Latency: done in cycle count+2 after start; no backpressure, one word per cycle.
module lfsr_pattern_sequencer
    import lfsr_seq_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    lfsr_pattern_sequencer_if.slave     bus
);

    state_e            state_q, state_d;
    logic [TAP_W-1:0]  tap_loc_q, tap_loc_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [7:0]        count_q, count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        words_left_q, words_left_d;
    logic              aborted_q, aborted_d;
    logic              lfsr_load;
    logic              lfsr_step;
    logic              mem_we;
    logic [LFSR_W-1:0] lfsr_val;

    always_comb begin
        state_d      = state_q;
        tap_loc_d    = tap_loc_q;
        seed_d       = seed_q;
        base_d       = base_q;
        stride_d     = stride_q;
        count_d      = count_q;
        mem_addr_d   = mem_addr_q;
        words_left_d = words_left_q;
        aborted_d    = aborted_q;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = LOAD;
                    tap_loc_d = bus.cfg_taps;
                    seed_d    = bus.cfg_seed;
                    base_d    = bus.cfg_base;
                    stride_d  = bus.cfg_stride;
                    count_d   = bus.cfg_count;
                end
            end
            LOAD: begin
                lfsr_load    = 1'b1;
                mem_addr_d   = base_q;
                words_left_d = count_q;
                if (bus.abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (count_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // An abort suppresses this cycle's write and freezes the datapath.
                if (bus.abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else begin
                    mem_we       = 1'b1;
                    lfsr_step    = 1'b1;
                    mem_addr_d   = mem_addr_q + stride_q;
                    words_left_d = words_left_q - 8'd1;
                    if (words_left_q == 8'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                aborted_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tap_loc_q    <= '0;
            seed_q       <= '0;
            base_q       <= '0;
            stride_q     <= '0;
            count_q      <= '0;
            mem_addr_q   <= '0;
            words_left_q <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_loc_q    <= tap_loc_d;
            seed_q       <= seed_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            words_left_q <= words_left_d;
            aborted_q    <= aborted_d;
        end
    end

    lfsr_shift_reg u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed_q),
        .taps  (tap_loc_q),
        .q     (lfsr_val)
    );

    assign bus.busy       = (state_q == LOAD) || (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.aborted    = aborted_q;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = lfsr_val;
    assign bus.lfsr_q     = lfsr_val;
    assign bus.tap_loc    = tap_loc_q;
    assign bus.words_left = words_left_q;

endmodule
